hsem_lock_master: RTL and testbench
===================================

// Module: hsem_lock_master
// PURPOSE
//  AHB-Lite master that sits directly upstream of the HSEM slave port. Turns one core-side
//  lock/unlock command into single AHB transfers: write the semaphore register, read it back to
//  confirm ownership, and retry with backoff on contention. Returns one response per command.
// PARAMETERS
//  SEM_BASE    32'h0000_0000  byte address of semaphore register 0; sem n at SEM_BASE+4*n
//  SEM_ID_W    5              width of semaphore index (32 semaphores)
//  MAX_RETRY   8              lock attempts before reporting failure (>=1)
//  BACKOFF_CYC 16             idle cycles between failed attempt and next attempt (>=1)
// PORTS
//  hclk       in   1         clock; all logic rising-edge
//  hreset     in   1         asynchronous reset, active-high
//  cmd_valid  in   1         command request
//  cmd_ready  out  1         command accepted when cmd_valid & cmd_ready
//  cmd_op     in   1         0 = lock, 1 = unlock
//  cmd_sem    in   SEM_ID_W  semaphore index
//  cmd_proc   in   8         requesting process ID
//  rsp_valid  out  1         one-cycle response pulse
//  rsp_ok     out  1         lock: ownership confirmed; unlock: write completed OKAY
//  rsp_err    out  1         bus ERROR response terminated the command
//  rsp_owner  out  8         owner ID from last read-back (lock only; 0 for unlock)
//  haddr      out  32        AHB address
//  htrans     out  2         2'b10 NONSEQ in address phase, 2'b00 IDLE otherwise
//  hwrite     out  1         transfer direction
//  hsize      out  3         fixed 3'b010
//  hburst     out  3         fixed 3'b000 (SINGLE)
//  hwdata     out  32        write data, valid in write data phase
//  hrdata     in   32        read data
//  hready     in   1         transfer complete / bus ready
//  hresp      in   2         2'b00 OKAY, 2'b01 ERROR
// BEHAVIOUR
//  Reset: state IDLE; cmd_ready=1, rsp_valid=0, rsp_ok=0, rsp_err=0, rsp_owner=0, haddr=0,
//   htrans=IDLE, hwrite=0, hwdata=0. Reset mid-transfer: htrans drops to IDLE at once,
//   command is lost, no response issued.
//  Register format: write bit31=LOCK, [7:0]=PROCID; read bit31=LOCKED, [7:0]=owner.
//  Command fields captured on accept; cmd_ready=1 only in IDLE. No pipelining: a write data
//   phase never overlaps a read address phase.
//  FSM: IDLE -> WR_A -> WR_D -> (lock) RD_A -> RD_D -> CHECK; (unlock) WR_D -> RESP.
//   WR_A/RD_A: htrans=NONSEQ, haddr=SEM_BASE+{cmd_sem,2'b00}; leave when hready=1.
//   WR_D: hwdata={cmd_op?1'b0:1'b1,23'b0,cmd_proc}, htrans=IDLE; leave when hready=1.
//   RD_D: sample hrdata when hready=1.
//   CHECK: success iff hrdata[31]=1 and hrdata[7:0]=cmd_proc -> RESP(ok=1);
//    else attempt count+1; if count==MAX_RETRY -> RESP(ok=0) else BACKOFF.
//   BACKOFF: count BACKOFF_CYC cycles, htrans=IDLE, then WR_A.
//   RESP: rsp_valid=1 one cycle, then IDLE (cmd_ready=1 next cycle).
//  Zero-wait latency (accept cycle = 0): lock success rsp_valid at cycle 5; unlock at cycle 3.
//   Each hready-low cycle in any phase adds one cycle.
//  ERROR: when hresp=ERROR in any data phase, at its hready=1 cycle go to RESP with rsp_err=1,
//   rsp_ok=0; no further transfers or retries. During ERROR first cycle (hready=0) htrans stays IDLE.
//  Attempt counter width clog2(MAX_RETRY+1); no wrap; reset to 0 on each accepted command.
//  rsp_owner holds last read-back value until next response; cleared to 0 for unlock.
// TESTING
//  Lock sem 3, proc 0x11, zero wait, readback 0x8000_0011 -> haddr 0x0C, rsp_ok=1 at cycle 5.
//  Lock contended: readback 0x8000_0022 always, MAX_RETRY=8 -> 8 write/read pairs, 16-cycle gaps,
//   rsp_ok=0, rsp_owner=0x22.
//  Unlock sem 31 proc 0x05 -> one write hwdata 0x0000_0005 at 0x7C, rsp_ok=1 at cycle 3.
//  hready low 3 cycles in RD_D -> haddr/htrans stable, rsp_valid delayed by exactly 3 cycles.
//  ERROR on write data phase -> no read issued, rsp_err=1, rsp_ok=0, next command accepted.
//  hreset pulse during BACKOFF -> htrans=IDLE, cmd_ready=1, no rsp_valid after release.

Source files
------------

// File: rtl/hsem_lock_master_if.sv
`default_nettype none
// ============================================================================
//  Module   : hsem_lock_master_if
//  Purpose  : Bundles the core-side command/response handshake and the
//             AHB-Lite master bus of hsem_lock_master.
//  Modports : master - the lock master (drives cmd_ready, rsp_*, AHB address
//                      and write data; receives cmd_*, hrdata, hready, hresp)
//             slave  - the far side (core + HSEM slave port)
//  Revision : 1.0 - initial release
// ============================================================================
interface hsem_lock_master_if #(
  parameter int SEM_ID_W = 5
);
  // Core command / response
  logic                cmd_valid;
  logic                cmd_ready;
  logic                cmd_op;
  logic [SEM_ID_W-1:0] cmd_sem;
  logic [7:0]          cmd_proc;
  logic                rsp_valid;
  logic                rsp_ok;
  logic                rsp_err;
  logic [7:0]          rsp_owner;
  // AHB-Lite master
  logic [31:0]         haddr;
  logic [1:0]          htrans;
  logic                hwrite;
  logic [2:0]          hsize;
  logic [2:0]          hburst;
  logic [31:0]         hwdata;
  logic [31:0]         hrdata;
  logic                hready;
  logic [1:0]          hresp;

  modport master (
    input  cmd_valid, cmd_op, cmd_sem, cmd_proc, hrdata, hready, hresp,
    output cmd_ready, rsp_valid, rsp_ok, rsp_err, rsp_owner,
           haddr, htrans, hwrite, hsize, hburst, hwdata
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_sem, cmd_proc, hrdata, hready, hresp,
    input  cmd_ready, rsp_valid, rsp_ok, rsp_err, rsp_owner,
           haddr, htrans, hwrite, hsize, hburst, hwdata
  );
endinterface
`default_nettype wire

// File: rtl/hsem_lock_master.sv
`default_nettype none
// ============================================================================
//  Module   : hsem_lock_master
//  Purpose  : AHB-Lite master in front of the HSEM slave. Turns one lock or
//             unlock command into single transfers (write semaphore, read it
//             back to confirm ownership, retry with backoff on contention)
//             and returns exactly one response per command.
//  Ports    : hclk   - clock, rising edge
//             hreset - asynchronous reset, active high
//             bus    - hsem_lock_master_if.master (cmd/rsp handshake + AHB)
//  Revision : 1.0 - initial release
// ============================================================================
module hsem_lock_master #(
  parameter logic [31:0] SEM_BASE    = 32'h0000_0000,
  parameter int          SEM_ID_W    = 5,
  parameter int          MAX_RETRY   = 8,
  parameter int          BACKOFF_CYC = 16
) (
  input  wire logic          hclk,
  input  wire logic          hreset,
  hsem_lock_master_if.master bus
);

  localparam int CNT_W = $clog2(MAX_RETRY + 1);
  localparam int BO_W  = $clog2(BACKOFF_CYC + 1);

  localparam logic [CNT_W-1:0] c_MAX_RETRY = CNT_W'(MAX_RETRY);
  localparam logic [BO_W-1:0]  c_BO_LAST   = BO_W'(BACKOFF_CYC - 1);

  localparam logic [1:0] c_HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] c_HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] c_HRESP_ERROR   = 2'b01;

  localparam logic [2:0] c_ST_IDLE    = 3'd0;
  localparam logic [2:0] c_ST_WR_A    = 3'd1;
  localparam logic [2:0] c_ST_WR_D    = 3'd2;
  localparam logic [2:0] c_ST_RD_A    = 3'd3;
  localparam logic [2:0] c_ST_RD_D    = 3'd4;
  localparam logic [2:0] c_ST_BACKOFF = 3'd5;
  localparam logic [2:0] c_ST_RESP    = 3'd6;

  logic [2:0]          r_state;
  logic [2:0]          w_state_nxt;
  logic                r_op;
  logic [SEM_ID_W-1:0] r_sem;
  logic [7:0]          r_proc;
  logic [CNT_W-1:0]    r_cnt;
  logic [BO_W-1:0]     r_bo;
  logic                r_rsp_ok;
  logic                r_rsp_err;
  logic [7:0]          r_rsp_owner;

  logic [CNT_W-1:0]    w_cnt_inc;
  logic                w_last_try;
  logic                w_bus_err;
  logic                w_rd_match;
  logic [31:0]         w_sem_addr;
  logic                w_unused_hrdata;

  logic                w_cmd_ready;
  logic                w_rsp_valid;
  logic [1:0]          w_htrans;
  logic                w_hwrite;
  logic [31:0]         w_haddr;
  logic [31:0]         w_hwdata;

  assign w_cnt_inc       = r_cnt + CNT_W'(1);
  assign w_last_try      = (w_cnt_inc == c_MAX_RETRY);
  assign w_bus_err       = (bus.hresp == c_HRESP_ERROR);
  assign w_rd_match      = bus.hrdata[31] && (bus.hrdata[7:0] == r_proc);
  assign w_sem_addr      = SEM_BASE + {{(30-SEM_ID_W){1'b0}}, r_sem, 2'b00};
  assign w_unused_hrdata = &{1'b0, bus.hrdata[30:8]};

  // State register
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) r_state <= c_ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic. The ownership check is folded into the read data
  // phase: the decision is made on the hready cycle that returns the
  // read-back word, so a successful lock responds in the following cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE:    if (bus.cmd_valid) w_state_nxt = c_ST_WR_A;
      c_ST_WR_A:    if (bus.hready)    w_state_nxt = c_ST_WR_D;
      c_ST_WR_D: begin
        if (bus.hready) begin
          if (w_bus_err || r_op) w_state_nxt = c_ST_RESP;
          else                   w_state_nxt = c_ST_RD_A;
        end
      end
      c_ST_RD_A:    if (bus.hready)    w_state_nxt = c_ST_RD_D;
      c_ST_RD_D: begin
        if (bus.hready) begin
          if (w_bus_err || w_rd_match || w_last_try) w_state_nxt = c_ST_RESP;
          else                                       w_state_nxt = c_ST_BACKOFF;
        end
      end
      c_ST_BACKOFF: if (r_bo == c_BO_LAST) w_state_nxt = c_ST_WR_A;
      c_ST_RESP:    w_state_nxt = c_ST_IDLE;
      default:      w_state_nxt = c_ST_IDLE;
    endcase
  end

  // Output logic: everything decodes from the registered state and captured
  // command, so a reset mid-transfer returns htrans to IDLE immediately.
  always_comb begin
    w_cmd_ready = 1'b0;
    w_rsp_valid = 1'b0;
    w_htrans    = c_HTRANS_IDLE;
    w_hwrite    = 1'b0;
    w_haddr     = 32'h0;
    w_hwdata    = 32'h0;
    case (r_state)
      c_ST_IDLE: w_cmd_ready = 1'b1;
      c_ST_WR_A: begin
        w_htrans = c_HTRANS_NONSEQ;
        w_hwrite = 1'b1;
        w_haddr  = w_sem_addr;
      end
      c_ST_WR_D: w_hwdata = {~r_op, 23'h0, r_proc};
      c_ST_RD_A: begin
        w_htrans = c_HTRANS_NONSEQ;
        w_haddr  = w_sem_addr;
      end
      c_ST_RESP: w_rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Command capture, attempt/backoff counters and response registers
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_op        <= 1'b0;
      r_sem       <= '0;
      r_proc      <= 8'h0;
      r_cnt       <= '0;
      r_bo        <= '0;
      r_rsp_ok    <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_owner <= 8'h0;
    end else begin
      r_bo <= (r_state == c_ST_BACKOFF) ? r_bo + BO_W'(1) : '0;
      case (r_state)
        c_ST_IDLE: begin
          if (bus.cmd_valid) begin
            r_op   <= bus.cmd_op;
            r_sem  <= bus.cmd_sem;
            r_proc <= bus.cmd_proc;
            r_cnt  <= '0;
          end
        end
        c_ST_WR_D: begin
          if (bus.hready) begin
            if (w_bus_err) begin
              r_rsp_ok  <= 1'b0;
              r_rsp_err <= 1'b1;
            end else if (r_op) begin
              r_rsp_ok    <= 1'b1;
              r_rsp_err   <= 1'b0;
              r_rsp_owner <= 8'h0;
            end
          end
        end
        c_ST_RD_D: begin
          if (bus.hready) begin
            if (w_bus_err) begin
              r_rsp_ok  <= 1'b0;
              r_rsp_err <= 1'b1;
            end else if (w_rd_match) begin
              r_rsp_ok    <= 1'b1;
              r_rsp_err   <= 1'b0;
              r_rsp_owner <= bus.hrdata[7:0];
            end else begin
              // Counter saturates at MAX_RETRY: the last failure leaves
              // for RESP instead of incrementing past it.
              r_cnt <= w_cnt_inc;
              if (w_last_try) begin
                r_rsp_ok    <= 1'b0;
                r_rsp_err   <= 1'b0;
                r_rsp_owner <= bus.hrdata[7:0];
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.cmd_ready = w_cmd_ready;
  assign bus.rsp_valid = w_rsp_valid;
  assign bus.rsp_ok    = r_rsp_ok;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.rsp_owner = r_rsp_owner;
  assign bus.haddr     = w_haddr;
  assign bus.htrans    = w_htrans;
  assign bus.hwrite    = w_hwrite;
  assign bus.hsize     = 3'b010;
  assign bus.hburst    = 3'b000;
  assign bus.hwdata    = w_hwdata;

endmodule
`default_nettype wire

// File: tb/tb_hsem_lock_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hsem_lock_master
//  Purpose  : Directed self-checking bench for hsem_lock_master. A cycle
//             loop plays the HSEM slave (wait states, ERROR responses,
//             programmable read-back) and records what the master issued.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hsem_lock_master;

  logic clk;
  logic rst;

  hsem_lock_master_if #(.SEM_ID_W(5)) bus ();

  hsem_lock_master #(
    .SEM_BASE    (32'h0000_0000),
    .SEM_ID_W    (5),
    .MAX_RETRY   (8),
    .BACKOFF_CYC (16)
  ) dut (
    .hclk   (clk),
    .hreset (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Results recorded by do_cmd
  int          res_cyc;
  logic        res_ok;
  logic        res_err;
  logic [7:0]  res_owner;
  int          n_wr;
  int          n_rd;
  logic [31:0] waddr;
  logic [31:0] raddr;
  logic [31:0] wdata;
  int          overlap;
  int          stall_bad;
  int          err_htrans_bad;
  int          gap_min;
  int          gap_max;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issues one command and acts as the AHB slave for up to 'budget' cycles
  // after the accept cycle (cycle 0), stopping at the response.
  task automatic do_cmd(input logic op, input logic [4:0] sem, input logic [7:0] proc,
                        input logic [31:0] rdata, input int rd_wait, input bit wr_err,
                        input int budget);
    int pend;
    int pend_cnt;
    int prev_wr_t;
    logic [31:0] stall_addr;
    logic [1:0]  stall_trans;
    @(negedge clk);
    check("accept_ready", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_sem   = sem;
    bus.cmd_proc  = proc;
    bus.hready    = 1'b1;
    bus.hresp     = 2'b00;
    bus.hrdata    = 32'h0;
    res_cyc = -1; res_ok = 1'b0; res_err = 1'b0; res_owner = 8'h0;
    n_wr = 0; n_rd = 0; overlap = 0; stall_bad = 0; err_htrans_bad = 0;
    waddr = 32'hx; raddr = 32'hx; wdata = 32'hx;
    gap_min = 100000; gap_max = 0; prev_wr_t = -1;
    pend = 0; pend_cnt = 0; stall_addr = 32'h0; stall_trans = 2'b00;
    for (int t = 1; t <= budget && res_cyc < 0; t++) begin
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      if (bus.rsp_valid) begin
        res_cyc   = t;
        res_ok    = bus.rsp_ok;
        res_err   = bus.rsp_err;
        res_owner = bus.rsp_owner;
      end
      bus.hready = 1'b1;
      bus.hresp  = 2'b00;
      bus.hrdata = 32'h0;
      if (pend == 1) begin
        wdata = bus.hwdata;
        if (wr_err) begin
          bus.hresp  = 2'b01;
          bus.hready = (pend_cnt >= 1);
          if (pend_cnt == 0 && bus.htrans !== 2'b00) err_htrans_bad++;
        end
      end else if (pend == 2) begin
        bus.hrdata = rdata;
        bus.hready = (pend_cnt >= rd_wait);
        if (pend_cnt == 0) begin
          stall_addr  = bus.haddr;
          stall_trans = bus.htrans;
        end else if (bus.haddr !== stall_addr || bus.htrans !== stall_trans) begin
          stall_bad++;
        end
      end
      if (bus.htrans == 2'b10) begin
        if (pend != 0) overlap++;
        if (bus.hwrite) begin
          n_wr++;
          waddr = bus.haddr;
          if (prev_wr_t >= 0) begin
            if (t - prev_wr_t < gap_min) gap_min = t - prev_wr_t;
            if (t - prev_wr_t > gap_max) gap_max = t - prev_wr_t;
          end
          prev_wr_t = t;
        end else begin
          n_rd++;
          raddr = bus.haddr;
        end
      end
      if (pend != 0) begin
        if (bus.hready) pend = 0;
        else            pend_cnt++;
      end
      if (bus.htrans == 2'b10 && bus.hready) begin
        pend     = bus.hwrite ? 1 : 2;
        pend_cnt = 0;
      end
    end
  endtask

  task automatic check_after_rsp(input string tag);
    @(negedge clk);
    check({tag, "_rsp_low"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, "_ready"},   32'(bus.cmd_ready), 32'd1);
  endtask

  int n_rsp_after;
  int n_trans_after;

  initial begin
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 1'b0;
    bus.cmd_sem   = 5'd0;
    bus.cmd_proc  = 8'h0;
    bus.hrdata    = 32'h0;
    bus.hready    = 1'b1;
    bus.hresp     = 2'b00;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_ok",    32'(bus.rsp_ok),    32'd0);
    check("rst_rsp_err",   32'(bus.rsp_err),   32'd0);
    check("rst_rsp_owner", 32'(bus.rsp_owner), 32'd0);
    check("rst_haddr",     bus.haddr,          32'h0);
    check("rst_htrans",    32'(bus.htrans),    32'd0);
    check("rst_hwrite",    32'(bus.hwrite),    32'd0);
    check("rst_hwdata",    bus.hwdata,         32'h0);
    check("rst_hsize",     32'(bus.hsize),     32'd2);
    check("rst_hburst",    32'(bus.hburst),    32'd0);
    rst = 1'b0;

    // Lock sem 3, proc 0x11, owner confirmed on first attempt
    do_cmd(1'b0, 5'd3, 8'h11, 32'h8000_0011, 0, 1'b0, 40);
    check("lk_cycle", 32'(res_cyc), 32'd5);
    check("lk_ok",    32'(res_ok),  32'd1);
    check("lk_err",   32'(res_err), 32'd0);
    check("lk_owner", 32'(res_owner), 32'h11);
    check("lk_n_wr",  32'(n_wr), 32'd1);
    check("lk_n_rd",  32'(n_rd), 32'd1);
    check("lk_waddr", waddr, 32'h0000_000C);
    check("lk_raddr", raddr, 32'h0000_000C);
    check("lk_wdata", wdata, 32'h8000_0011);
    check("lk_overlap", 32'(overlap), 32'd0);
    check_after_rsp("lk");

    // Unlock sem 31, proc 0x05: one write, no read-back
    do_cmd(1'b1, 5'd31, 8'h05, 32'h0, 0, 1'b0, 40);
    check("ul_cycle", 32'(res_cyc), 32'd3);
    check("ul_ok",    32'(res_ok),  32'd1);
    check("ul_err",   32'(res_err), 32'd0);
    check("ul_owner", 32'(res_owner), 32'h0);
    check("ul_n_wr",  32'(n_wr), 32'd1);
    check("ul_n_rd",  32'(n_rd), 32'd0);
    check("ul_waddr", waddr, 32'h0000_007C);
    check("ul_wdata", wdata, 32'h0000_0005);
    check_after_rsp("ul");

    // Contended lock: 8 attempts spaced 4 transfer cycles + 16 backoff,
    // last read phase at cycle 144, response at 145
    do_cmd(1'b0, 5'd3, 8'h11, 32'h8000_0022, 0, 1'b0, 300);
    check("ct_n_wr",   32'(n_wr), 32'd8);
    check("ct_n_rd",   32'(n_rd), 32'd8);
    check("ct_gap_min", 32'(gap_min), 32'd20);
    check("ct_gap_max", 32'(gap_max), 32'd20);
    check("ct_cycle",  32'(res_cyc), 32'd145);
    check("ct_ok",     32'(res_ok),  32'd0);
    check("ct_err",    32'(res_err), 32'd0);
    check("ct_owner",  32'(res_owner), 32'h22);
    check("ct_overlap", 32'(overlap), 32'd0);
    check_after_rsp("ct");

    // Three wait states in the read data phase delay the response by 3
    do_cmd(1'b0, 5'd3, 8'h11, 32'h8000_0011, 3, 1'b0, 40);
    check("ws_cycle",  32'(res_cyc), 32'd8);
    check("ws_stable", 32'(stall_bad), 32'd0);
    check("ws_ok",     32'(res_ok), 32'd1);

    // ERROR on the write data phase: no read, error response
    do_cmd(1'b0, 5'd2, 8'h33, 32'h8000_0033, 0, 1'b1, 40);
    check("er_cycle",  32'(res_cyc), 32'd4);
    check("er_err",    32'(res_err), 32'd1);
    check("er_ok",     32'(res_ok),  32'd0);
    check("er_n_rd",   32'(n_rd), 32'd0);
    check("er_htrans", 32'(err_htrans_bad), 32'd0);
    check_after_rsp("er");

    // Next command after the error goes through normally
    do_cmd(1'b1, 5'd0, 8'h01, 32'h0, 0, 1'b0, 40);
    check("pe_cycle", 32'(res_cyc), 32'd3);
    check("pe_ok",    32'(res_ok),  32'd1);
    check("pe_err",   32'(res_err), 32'd0);
    check("pe_waddr", waddr, 32'h0);

    // Reset pulse while backing off after a failed attempt (cycle 10)
    do_cmd(1'b0, 5'd4, 8'h11, 32'h8000_0022, 0, 1'b0, 10);
    check("rb_no_rsp", 32'(res_cyc), 32'hFFFF_FFFF);
    check("rb_busy",   32'(bus.cmd_ready), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("rb_htrans", 32'(bus.htrans), 32'd0);
    check("rb_ready",  32'(bus.cmd_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    n_rsp_after = 0;
    n_trans_after = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) n_rsp_after++;
      if (bus.htrans != 2'b00) n_trans_after++;
    end
    check("rb_rsp_after",   32'(n_rsp_after), 32'd0);
    check("rb_trans_after", 32'(n_trans_after), 32'd0);
    check("rb_ready_after", 32'(bus.cmd_ready), 32'd1);

    // Lock after the reset still works
    do_cmd(1'b0, 5'd1, 8'h44, 32'h8000_0044, 0, 1'b0, 40);
    check("pr_cycle", 32'(res_cyc), 32'd5);
    check("pr_ok",    32'(res_ok),  32'd1);
    check("pr_waddr", waddr, 32'h0000_0004);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
